axi_rr_burst_arbiter: RTL

Parametrised round-robin arbiter with an integrated payload multiplexer. It succeeds the tree arbiter, which uses a counter-based shift for priority.
- Fairness is driven by a last-granted pointer and works for any NUM_REQ, including non-powers-of-two.
- A selection is held stable while the downstream port stalls (AXI valid/ready stability).
- Optionally, the grant is held across a multi-beat burst until the beat flagged last.
- Sits in front of shared AXI channels (AW/AR single-beat, W multi-beat) in crossbars and muxes.

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/rr_prio_select.sv | 35 +++
 rtl/axi_rr_burst_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and helpers for the round-robin AXI arbiter family.
package axi_arb_pkg;

  // Arbitration mode a parent crossbar can use to pick BURST_HOLD.
  typedef enum logic {
    ARB_SINGLE = 1'b0,
    ARB_BURST  = 1'b1
  } arb_mode_e;

  // Lock state of the selection: free to re-arbitrate or held on one requestor.
  typedef enum logic {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  // Index width that never collapses to zero bits for a single requestor.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Round-robin priority search: lowest request at or above the pointer, else the
// lowest request overall. Uses a double-width vector so the wrap needs no modulo.
module rr_prio_select
  import axi_arb_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any_valid
);

  logic [NUM_REQ-1:0]   mask_ge;
  logic [2*NUM_REQ-1:0] dbl_req;

  // Masked copy in the low half wins over the unmasked copy in the high half.
  always_comb begin
    mask_ge   = '0;
    idx       = '0;
    any_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask_ge[i] = (IDX_W'(i) >= ptr);
    end
    dbl_req = {req, req & mask_ge};
    for (int j = 0; j < 2 * NUM_REQ; j++) begin
      if (!any_valid && dbl_req[j]) begin
        any_valid = 1'b1;
        idx       = (j < NUM_REQ) ? IDX_W'(j) : IDX_W'(j - NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/axi_rr_burst_arbiter.sv
// Round-robin arbiter with payload mux, stall lock-in and optional burst hold.
module axi_rr_burst_arbiter
  import axi_arb_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  parameter int  LOCK_IN    = 1,
  parameter int  BURST_HOLD = 0,
  localparam int IDX_W      = clog2_min1(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 last_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [DATA_WIDTH-1:0]              data_o,
  output logic [IDX_W-1:0]                   idx_o
);

  lock_state_e      lock_q, lock_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] prio_idx;
  logic             any_valid;
  logic [IDX_W-1:0] sel;

  rr_prio_select #(
    .NUM_REQ (NUM_REQ)
  ) u_prio (
    .req       (req_i),
    .ptr       (rr_q),
    .idx       (prio_idx),
    .any_valid (any_valid)
  );

  // Pick the locked requestor if held, otherwise the round-robin winner; drive outputs.
  always_comb begin
    sel     = (lock_q == LOCK_HELD) ? lock_idx_q : prio_idx;
    valid_o = (lock_q == LOCK_HELD) ? req_i[lock_idx_q] : any_valid;
    data_o  = data_i[sel];
    idx_o   = sel;
    gnt_o   = '0;
    if (valid_o && ready_i) begin
      gnt_o[sel] = 1'b1;
    end
  end

  // Next pointer and lock state; flush overrides any handshake update.
  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (flush_i) begin
      rr_d   = '0;
      lock_d = LOCK_FREE;
    end else if (valid_o && ready_i) begin
      if ((BURST_HOLD != 0) && !last_i[sel]) begin
        lock_d     = LOCK_HELD;
        lock_idx_d = sel;
      end else begin
        lock_d = LOCK_FREE;
        rr_d   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
      end
    end else if (valid_o && !ready_i && (LOCK_IN != 0)) begin
      lock_d     = LOCK_HELD;
      lock_idx_d = sel;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= LOCK_FREE;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  a_num_req_range : assert property (@(posedge clk_i) (NUM_REQ >= 1) && (NUM_REQ <= 64))
    else $error("NUM_REQ %0d outside 1..64", NUM_REQ);

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o))
    else $error("gnt_o not onehot0: %b", gnt_o);

  a_locked_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lock_q == LOCK_HELD) |-> req_i[lock_idx_q])
    else $warning("Locked requestor %0d dropped its request", lock_idx_q);

  if (LOCK_IN != 0) begin : g_stall_stable
    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o)))
      else $error("valid_o/data_o changed during a stall");
  end

endmodule
